mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: BigEndian, default 1, meaning byte 0 of a word is bits 31:24 (0 selects little-endian, byte 0 = bits 7:0).
REQ-002 Parameter: ReadWait, default 1, meaning the number of cycles Mem_rd/Mem_Addr are held before Mem_DOUT is sampled (legal 1..15).
REQ-003 Port: CLK  in  1  clock; all state changes on rising edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high.
REQ-005 Port: Req  in  1  access request, sampled only in IDLE.
REQ-006 Port: Wr  in  1  1 = store, 0 = load.
REQ-007 Port: Size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-008 Port: Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 Port: Addr  in  32  byte address.
REQ-010 Port: WData  in  32  store data, right-justified for byte and half.
REQ-011 Port: RData  out  32  extended load result.
REQ-012 Port: Busy  out  1  high in every state except IDLE.
REQ-013 Port: Done  out  1  one-cycle completion pulse.
REQ-014 Port: Err  out  1  one-cycle misalignment pulse, coincident with Done.
REQ-015 Port: Mem_Addr  out  32  word-aligned address to the data memory, {Addr[31:2],2'b00}.
REQ-016 Port: Mem_rd  out  1  memory read strobe.
REQ-017 Port: Mem_wr  out  1  memory write strobe; the memory commits on the falling edge of CLK.
REQ-018 Port: Mem_DIN  out  32  memory write data.
REQ-019 Port: Mem_DOUT  in  32  memory read data.

Function
REQ-020 FSM states:
- IDLE, READ, WRITE, DONE, registered.
- Outputs are decoded from state and captured registers only; there is no combinational path from Req to the memory strobes.
REQ-021 In IDLE with Req=1, the unit SHALL capture Addr, WData, Size, Wr and Unsigned at the edge; later input changes have no effect until the next IDLE.
REQ-022 Misaligned requests SHALL go IDLE→DONE with Err=1 and no Mem_rd/Mem_wr pulse:
- half with Addr[0]=1
- word with Addr[1:0]≠0
REQ-023 Aligned word store: IDLE→WRITE (1 cycle, Mem_wr=1, Mem_DIN=WData)→DONE.
REQ-024 Load: IDLE→READ for exactly ReadWait cycles with Mem_rd=1; Mem_DOUT is sampled at the last READ edge; then →DONE.
REQ-025 Sub-word store (read-modify-write): IDLE→READ (ReadWait cycles)→WRITE→DONE.
- Mem_DIN in WRITE = sampled word with only the addressed byte/half lane replaced by WData[7:0]/WData[15:0].
REQ-026 Lane select:
- byte lane = Addr[1:0]
- half lane = Addr[1]
- lane bit positions per BigEndian
REQ-027 Load extension: the byte/half is sign-extended (Unsigned=0) or zero-extended (Unsigned=1) into RData; a word load passes unchanged.
REQ-028 DONE lasts exactly 1 cycle with Done=1, then returns to IDLE; a Req present during DONE is ignored.
REQ-029 Mem_rd and Mem_wr SHALL never be 1 in the same cycle.
- Mem_Addr stays constant from the first READ cycle through WRITE.
- Mem_Addr, Mem_DIN, Mem_rd and Mem_wr are 0 in IDLE and DONE.
REQ-030 RData updates only when a load completes (at the entry edge to DONE) and holds its value otherwise; stores and Err never change it.
REQ-031 Latency from the Req edge to the Done cycle:
- SW: 2 cycles
- load: ReadWait+1 cycles
- SB/SH: ReadWait+2 cycles
- misaligned: 1 cycle

Reset
REQ-032 Reset=1 at a rising edge SHALL force IDLE and clear RData, Done, Err, Busy, Mem_rd, Mem_wr, Mem_Addr and Mem_DIN to 0; reset takes priority over Req.
REQ-033 Reset asserted mid-access SHALL abort the access with no Done pulse.
- A write whose falling edge has already occurred is not undone.
- A WRITE state cut by reset before its falling edge leaves Mem_wr=0 from that rising edge on.

Verification
REQ-034 LW, Addr=0x10, ReadWait=1, Mem_DOUT=0x8899AABB → Mem_rd high 1 cycle at Mem_Addr 0x10; Done 2 cycles after Req; RData=0x8899AABB.
REQ-035 LB vs LBU, Addr=0x13, BigEndian=1, word=0x112233F4:
- LB → RData=0xFFFFFFF4
- LBU → RData=0x000000F4
- LH at Addr=0x12 → 0x000033F4
REQ-036 SB, Addr=0x21, WData=0x000000CC, stored word 0x11223344, ReadWait=2 → READ 2 cycles, then WRITE with Mem_DIN=0x11CC3344; Done at Req+4; strobes never overlap.
REQ-037 LW at Addr=0x06 → Err=Done=1 one cycle after Req; Mem_rd/Mem_wr stay 0; RData unchanged.
REQ-038 Reset raised during READ of an SH → next cycle IDLE, all outputs 0, no Done and no Mem_wr ever; a following LW completes normally.
REQ-039 Req held high for 10 cycles with SW requests → Done once every 3 cycles (WRITE, DONE, IDLE accept); each Mem_wr pulse is 1 cycle wide.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Requester and data-memory signals of mem_access_unit. The unit is the slave of the
// requester and the master of the memory. The master modport is the requester/memory side.
interface mem_access_unit_if;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [31:0] Mem_Addr;
  logic        Mem_rd;
  logic        Mem_wr;
  logic [31:0] Mem_DIN;
  logic [31:0] Mem_DOUT;

  modport master (
    output Req, Wr, Size, Unsigned, Addr, WData, Mem_DOUT,
    input  RData, Busy, Done, Err, Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );

  modport slave (
    input  Req, Wr, Size, Unsigned, Addr, WData, Mem_DOUT,
    output RData, Busy, Done, Err, Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for a word-wide data memory: lane select, load extension, alignment check, RMW sub-word stores.
// Latency from the Req edge to Done: SW 2, load ReadWait+1, SB/SH ReadWait+2, misaligned 1; Req is only accepted in IDLE.
module mem_access_unit #(
  parameter int BigEndian = 1,
  parameter int ReadWait  = 1
) (
  input logic              CLK,
  input logic              Reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] READ_LAST = 4'(ReadWait - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q, uns_q, err_q;
  logic [3:0]  rd_cnt;
  logic [31:0] din_q, rdata_q;

  logic        req_byte, req_half, req_misaligned;
  logic        cur_byte, cur_half, read_last;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask, wdata_lane, load_val, merged;
  logic [15:0] lane_word;

  // Request decode works on the live inputs; it only matters in the IDLE capture cycle.
  always_comb begin
    req_byte       = bus.Size == 2'b00;
    req_half       = bus.Size == 2'b01;
    req_misaligned = (req_half && bus.Addr[0]) ||
                     (!req_byte && !req_half && bus.Addr[1:0] != 2'b00);
  end

  always_comb begin
    cur_byte  = size_q == 2'b00;
    cur_half  = size_q == 2'b01;
    read_last = (state == READ) && (rd_cnt == READ_LAST);
    if (cur_half) begin
      lane_shift = (BigEndian != 0) ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
      lane_mask  = 32'h0000_FFFF << lane_shift;
      wdata_lane = {16'h0000, wdata_q} << lane_shift;
    end else begin
      lane_shift = (BigEndian != 0) ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
      lane_mask  = 32'h0000_00FF << lane_shift;
      wdata_lane = {24'h000000, wdata_q[7:0]} << lane_shift;
    end
    lane_word = 16'(bus.Mem_DOUT >> lane_shift);
    if (cur_byte) begin
      load_val = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
    end else if (cur_half) begin
      load_val = {{16{~uns_q & lane_word[15]}}, lane_word};
    end else begin
      load_val = bus.Mem_DOUT;
    end
    merged = (bus.Mem_DOUT & ~lane_mask) | wdata_lane;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          if (req_misaligned) begin
            state_nxt = DONE;
          end else if (bus.Wr && !req_byte && !req_half) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ:    if (read_last) state_nxt = wr_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a decode of the state register and captured data, never of Req.
  assign bus.Busy     = state != IDLE;
  assign bus.Done     = state == DONE;
  assign bus.Err      = (state == DONE) && err_q;
  assign bus.Mem_rd   = state == READ;
  assign bus.Mem_wr   = state == WRITE;
  assign bus.Mem_Addr = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.Mem_DIN  = (state == WRITE) ? din_q : 32'h0;
  assign bus.RData    = rdata_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_cnt  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.Req) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData[15:0];
        size_q  <= bus.Size;
        wr_q    <= bus.Wr;
        uns_q   <= bus.Unsigned;
        err_q   <= req_misaligned;
        din_q   <= bus.WData;
        rd_cnt  <= '0;
      end
      if (state == READ) begin
        rd_cnt <= rd_cnt + 4'd1;
        // The last READ edge either finishes a load or builds the RMW write word.
        if (read_last) begin
          if (wr_q) begin
            din_q <= merged;
          end else begin
            rdata_q <= load_val;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (BE/RW=1, BE/RW=2, LE/RW=3) see the same stimulus;
// predicted outcomes are queued when a request is driven and popped when each access completes.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int NDUT = 3;

  function automatic int rw_of(input int d);
    return d + 1;
  endfunction

  function automatic int be_of(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  typedef struct {
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] din;
    logic [31:0] maddr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] pre;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, req, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic [NDUT-1:0] busy_v, done_v, err_v, rd_v, wr_v;
  logic [31:0] rdata_v [NDUT];
  logic [31:0] maddr_v [NDUT];
  logic [31:0] din_v   [NDUT];
  logic [31:0] mem     [NDUT][16];
  logic [31:0] ref_mem [NDUT][16];
  logic [31:0] exp_rdata [NDUT];

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int          o_lat [NDUT];
  int          o_nrd [NDUT];
  int          o_nwr [NDUT];
  int          o_bad [NDUT];
  logic [31:0] o_din [NDUT];
  logic [31:0] o_addr[NDUT];
  logic [31:0] o_rdata[NDUT];
  logic        o_err [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_access_unit_if bus();
    assign bus.Req      = req;
    assign bus.Wr       = wr;
    assign bus.Size     = size;
    assign bus.Unsigned = uns;
    assign bus.Addr     = addr;
    assign bus.WData    = wdata;
    assign bus.Mem_DOUT = mem[g][bus.Mem_Addr[5:2]];
    assign busy_v[g]    = bus.Busy;
    assign done_v[g]    = bus.Done;
    assign err_v[g]     = bus.Err;
    assign rd_v[g]      = bus.Mem_rd;
    assign wr_v[g]      = bus.Mem_wr;
    assign rdata_v[g]   = bus.RData;
    assign maddr_v[g]   = bus.Mem_Addr;
    assign din_v[g]     = bus.Mem_DIN;
    mem_access_unit #(.BigEndian(be_of(g)), .ReadWait(rw_of(g))) u_dut (
      .CLK  (clk),
      .Reset(rst),
      .bus  (bus)
    );
  end

  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k, input int be);
    int pos = (be != 0) ? 3 - k : k;
    return w[8*pos +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input int be,
                                           input logic [7:0] v);
    logic [31:0] r = w;
    int pos = (be != 0) ? 3 - k : k;
    r[8*pos +: 8] = v;
    return r;
  endfunction

  // Reference model: byte-addressed view of the word, independent of any shifting scheme.
  function automatic exp_t predict(input int d, input req_t r);
    exp_t        e;
    int          k    = int'(r.a[1:0]);
    int          rw   = rw_of(d);
    int          be   = be_of(d);
    logic [31:0] word = ref_mem[d][r.a[5:2]];
    logic [7:0]  b;
    logic [15:0] h;
    e.maddr = {r.a[31:2], 2'b00};
    e.din   = '0;
    e.err   = 1'b0;
    e.nrd   = 0;
    e.nwr   = 0;
    e.rdata = exp_rdata[d];
    if ((r.sz == 2'b01 && r.a[0]) || (r.sz[1] && r.a[1:0] != 2'b00)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (r.w && r.sz[1]) begin
      e.lat = 2;
      e.nwr = 1;
      e.din = r.wd;
    end else if (r.w) begin
      e.lat = rw + 2;
      e.nrd = rw;
      e.nwr = 1;
      if (r.sz == 2'b00) e.din = put_byte(word, k, be, r.wd[7:0]);
      else e.din = put_byte(put_byte(word, k, be, (be != 0) ? r.wd[15:8] : r.wd[7:0]),
                            k + 1, be, (be != 0) ? r.wd[7:0] : r.wd[15:8]);
    end else begin
      e.lat = rw + 1;
      e.nrd = rw;
      if (r.sz == 2'b00) begin
        b = get_byte(word, k, be);
        e.rdata = r.u ? {24'h0, b} : {{24{b[7]}}, b};
      end else if (r.sz == 2'b01) begin
        h = (be != 0) ? {get_byte(word, k, be), get_byte(word, k + 1, be)}
                      : {get_byte(word, k + 1, be), get_byte(word, k, be)};
        e.rdata = r.u ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        e.rdata = word;
      end
      exp_rdata[d] = e.rdata;
    end
    if (e.nwr > 0) ref_mem[d][r.a[5:2]] = e.din;
    return e;
  endfunction

  task automatic start_req(input req_t r);
    for (int d = 0; d < NDUT; d++) begin
      mem[d][r.a[5:2]]     = r.pre;
      ref_mem[d][r.a[5:2]] = r.pre;
    end
    @(posedge clk); #1;
    req = 1'b1; wr = r.w; size = r.sz; uns = r.u; addr = r.a; wdata = r.wd;
    for (int d = 0; d < NDUT; d++) exp_q.push_back(predict(d, r));
  endtask

  // Watches all instances cycle by cycle until each shows Done; the memory commits on negedge.
  task automatic observe(input int budget);
    logic [NDUT-1:0] fin = '0;
    for (int d = 0; d < NDUT; d++) begin
      o_lat[d] = -1; o_nrd[d] = 0; o_nwr[d] = 0; o_bad[d] = 0;
      o_din[d] = '0; o_addr[d] = '0; o_rdata[d] = '0; o_err[d] = 1'b0;
    end
    for (int c = 1; c <= budget && fin != '1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req = 1'b0; addr = $urandom; wdata = $urandom;
        size = 2'($urandom); wr = 1'($urandom); uns = 1'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (!fin[d]) begin
          if (rd_v[d] && wr_v[d]) o_bad[d]++;
          if (rd_v[d] || wr_v[d]) begin
            if (o_nrd[d] + o_nwr[d] == 0) o_addr[d] = maddr_v[d];
            else if (maddr_v[d] != o_addr[d]) o_bad[d]++;
          end
          if (rd_v[d]) o_nrd[d]++;
          if (wr_v[d]) begin
            o_nwr[d]++;
            o_din[d] = din_v[d];
            mem[d][maddr_v[d][5:2]] = din_v[d];
          end
          if (done_v[d]) begin
            fin[d]     = 1'b1;
            o_lat[d]   = c;
            o_rdata[d] = rdata_v[d];
            o_err[d]   = err_v[d];
            if (rd_v[d] || wr_v[d] || maddr_v[d] != 0 || din_v[d] != 0) o_bad[d]++;
          end else if (err_v[d]) begin
            o_bad[d]++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; wdata = '0;
    for (int d = 0; d < NDUT; d++) exp_rdata[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_v !== '0) begin errors++; $display("FAIL reset busy: got %b, want 000", busy_v); end
    checks++; if ((done_v | err_v) !== '0) begin errors++; $display("FAIL reset done/err: got %b/%b, want 0", done_v, err_v); end
    checks++; if ((rd_v | wr_v) !== '0) begin errors++; $display("FAIL reset strobes: got %b/%b, want 0", rd_v, wr_v); end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ((rdata_v[d] | maddr_v[d] | din_v[d]) !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d buses: rdata %h addr %h din %h, want 0", d, rdata_v[d], maddr_v[d], din_v[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
  endtask

  task automatic test_loads();
    req_t tbl [6] = '{
      '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB},
      '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h112233F4},
      '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h112233F4},
      '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h112233F4},
      '{1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'hF00DBEEF},
      '{1'b0, 2'b11, 1'b0, 32'h18, 32'h0, 32'hCAFE0123}
    };
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      start_req(tbl[i]);
      observe(12);
      for (int d = 0; d < NDUT; d++) begin
        e = exp_q.pop_front();
        checks++; if (o_lat[d] !== e.lat) begin errors++; $display("FAIL load[%0d] dut%0d latency: got %0d, want %0d", i, d, o_lat[d], e.lat); end
        checks++; if (o_nrd[d] !== e.nrd || o_nwr[d] !== 0) begin errors++; $display("FAIL load[%0d] dut%0d strobes: rd %0d wr %0d, want rd %0d wr 0", i, d, o_nrd[d], o_nwr[d], e.nrd); end
        checks++; if (o_addr[d] !== e.maddr) begin errors++; $display("FAIL load[%0d] dut%0d mem_addr: got %h, want %h", i, d, o_addr[d], e.maddr); end
        checks++; if (o_rdata[d] !== e.rdata) begin errors++; $display("FAIL load[%0d] dut%0d rdata: got %h, want %h", i, d, o_rdata[d], e.rdata); end
        checks++; if (o_err[d] !== e.err || o_bad[d] !== 0) begin errors++; $display("FAIL load[%0d] dut%0d err/protocol: err %b bad %0d, want %b/0", i, d, o_err[d], o_bad[d], e.err); end
      end
    end
  endtask

  task automatic test_stores();
    req_t tbl [5] = '{
      '{1'b1, 2'b00, 1'b0, 32'h21, 32'h000000CC, 32'h11223344},
      '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h55667788},
      '{1'b1, 2'b01, 1'b0, 32'h24, 32'hFFFF1234, 32'h00000000},
      '{1'b1, 2'b10, 1'b0, 32'h28, 32'hDEADBEEF, 32'h00000000},
      '{1'b1, 2'b00, 1'b0, 32'h2F, 32'h0000005A, 32'hFFFFFFFF}
    };
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_req(tbl[i]);
      observe(12);
      for (int d = 0; d < NDUT; d++) begin
        e = exp_q.pop_front();
        checks++; if (o_lat[d] !== e.lat) begin errors++; $display("FAIL store[%0d] dut%0d latency: got %0d, want %0d", i, d, o_lat[d], e.lat); end
        checks++; if (o_nrd[d] !== e.nrd || o_nwr[d] !== e.nwr) begin errors++; $display("FAIL store[%0d] dut%0d strobes: rd %0d wr %0d, want rd %0d wr %0d", i, d, o_nrd[d], o_nwr[d], e.nrd, e.nwr); end
        checks++; if (o_din[d] !== e.din) begin errors++; $display("FAIL store[%0d] dut%0d mem_din: got %h, want %h", i, d, o_din[d], e.din); end
        checks++; if (o_addr[d] !== e.maddr) begin errors++; $display("FAIL store[%0d] dut%0d mem_addr: got %h, want %h", i, d, o_addr[d], e.maddr); end
        checks++; if (o_rdata[d] !== e.rdata || o_err[d] !== 1'b0 || o_bad[d] !== 0) begin errors++; $display("FAIL store[%0d] dut%0d rdata/err/protocol: %h %b %0d, want %h 0 0", i, d, o_rdata[d], o_err[d], o_bad[d], e.rdata); end
        checks++; if (mem[d][tbl[i].a[5:2]] !== ref_mem[d][tbl[i].a[5:2]]) begin errors++; $display("FAIL store[%0d] dut%0d memory word: got %h, want %h", i, d, mem[d][tbl[i].a[5:2]], ref_mem[d][tbl[i].a[5:2]]); end
      end
    end
  endtask

  task automatic test_misaligned();
    req_t tbl [5] = '{
      '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h01020304},
      '{1'b1, 2'b10, 1'b0, 32'h05, 32'h99999999, 32'h01020304},
      '{1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h05060708},
      '{1'b1, 2'b01, 1'b0, 32'h01, 32'h00007777, 32'h0A0B0C0D},
      '{1'b0, 2'b11, 1'b0, 32'h0A, 32'h0, 32'h0E0F1011}
    };
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_req(tbl[i]);
      observe(12);
      for (int d = 0; d < NDUT; d++) begin
        e = exp_q.pop_front();
        checks++; if (o_lat[d] !== e.lat || o_err[d] !== e.err) begin errors++; $display("FAIL misaligned[%0d] dut%0d latency/err: got %0d/%b, want %0d/%b", i, d, o_lat[d], o_err[d], e.lat, e.err); end
        checks++; if (o_nrd[d] + o_nwr[d] !== 0 || o_bad[d] !== 0) begin errors++; $display("FAIL misaligned[%0d] dut%0d strobes: rd %0d wr %0d bad %0d, want 0", i, d, o_nrd[d], o_nwr[d], o_bad[d]); end
        checks++; if (o_rdata[d] !== e.rdata) begin errors++; $display("FAIL misaligned[%0d] dut%0d rdata held: got %h, want %h", i, d, o_rdata[d], e.rdata); end
        checks++; if (mem[d][tbl[i].a[5:2]] !== tbl[i].pre) begin errors++; $display("FAIL misaligned[%0d] dut%0d memory word: got %h, want %h", i, d, mem[d][tbl[i].a[5:2]], tbl[i].pre); end
      end
    end
  endtask

  // SW requests with Req held for cycles 0..9: accept/WRITE/DONE repeats every 3 cycles.
  task automatic test_back_to_back();
    int nwr [NDUT];
    int ndone [NDUT];
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'hA0000000;
    for (int d = 0; d < NDUT; d++) begin nwr[d] = 0; ndone[d] = 0; end
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c <= 9) wdata = 32'hA0000000 + 32'(c);
      if (c == 10) req = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (wr_v[d]) begin
          nwr[d]++;
          mem[d][maddr_v[d][5:2]] = din_v[d];
          checks++; if (c % 3 != 1 || din_v[d] !== 32'hA0000000 + 32'(c - 1)) begin errors++; $display("FAIL b2b dut%0d write cycle %0d: din %h, want cycle 1 mod 3 with din %h", d, c, din_v[d], 32'hA0000000 + 32'(c - 1)); end
        end
        if (done_v[d]) begin
          ndone[d]++;
          checks++; if (c % 3 != 2) begin errors++; $display("FAIL b2b dut%0d done cycle: got %0d, want 2 mod 3", d, c); end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (nwr[d] !== 4 || ndone[d] !== 4) begin errors++; $display("FAIL b2b dut%0d counts: wr %0d done %0d, want 4/4", d, nwr[d], ndone[d]); end
    end
  endtask

  // Reset lands while every instance is in READ of an SH; then a plain LW must still work.
  task automatic test_reset_abort();
    req_t sh = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h00007777, 32'h12345678};
    req_t lw = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB};
    exp_t e;
    int   late_done = 0;
    int   late_wr   = 0;
    start_req(sh);
    for (int d = 0; d < NDUT; d++) begin
      e = exp_q.pop_front();
      ref_mem[d][sh.a[5:2]] = sh.pre;
      exp_rdata[d] = '0;
    end
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_v !== '1) begin errors++; $display("FAIL abort pre-reset read: got %b, want 111", rd_v); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ((busy_v | done_v | err_v | rd_v | wr_v) !== '0) begin errors++; $display("FAIL abort outputs: busy %b done %b rd %b wr %b, want 0", busy_v, done_v, rd_v, wr_v); end
    for (int d = 0; d < NDUT; d++) begin
      checks++; if ((rdata_v[d] | maddr_v[d] | din_v[d]) !== 32'h0) begin errors++; $display("FAIL abort dut%0d buses: rdata %h addr %h din %h, want 0", d, rdata_v[d], maddr_v[d], din_v[d]); end
    end
    repeat (8) begin
      @(negedge clk);
      if (done_v != '0) late_done++;
      if (wr_v != '0) late_wr++;
    end
    checks++; if (late_done !== 0 || late_wr !== 0) begin errors++; $display("FAIL abort after reset: done cycles %0d wr cycles %0d, want 0", late_done, late_wr); end
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (mem[d][sh.a[5:2]] !== sh.pre) begin errors++; $display("FAIL abort dut%0d memory word: got %h, want %h", d, mem[d][sh.a[5:2]], sh.pre); end
    end
    start_req(lw);
    observe(12);
    for (int d = 0; d < NDUT; d++) begin
      e = exp_q.pop_front();
      checks++; if (o_lat[d] !== e.lat || o_rdata[d] !== e.rdata) begin errors++; $display("FAIL abort-then-lw dut%0d: latency %0d rdata %h, want %0d %h", d, o_lat[d], o_rdata[d], e.lat, e.rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
